// File: rtl/pipe_stage_skid_reg.sv
// rtl/pipe_stage_skid_reg.sv - pipeline register with 2-entry skid buffer, flush and stall counter
module pipe_stage_skid_reg #(
  parameter int DATA_W = 69,
  parameter int CTRL_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              m_valid;
  logic              accept;
  logic              drain;

  assign m_valid = (state_q != EMPTY);
  assign accept  = in_valid & in_ready_q;
  assign drain   = m_valid & out_ready;

  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    m_ctrl_d = m_ctrl_q;
    s_data_d = s_data_q;
    s_ctrl_d = s_ctrl_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          m_data_d = in_data;
          m_ctrl_d = in_ctrl;
          state_d  = ONE;
        end
      end
      ONE: begin
        if (accept && drain) begin
          m_data_d = in_data;
          m_ctrl_d = in_ctrl;
        end else if (accept) begin
          s_data_d = in_data;
          s_ctrl_d = in_ctrl;
          state_d  = FULL;
        end else if (drain) begin
          state_d  = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the skid-to-main move can happen
        if (drain) begin
          m_data_d = s_data_q;
          m_ctrl_d = s_ctrl_q;
          state_d  = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d  = EMPTY;
      m_ctrl_d = '0;
      s_ctrl_d = '0;
    end
    in_ready_d = (state_d != FULL);
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (m_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      m_data_q    <= '0;
      m_ctrl_q    <= '0;
      s_data_q    <= '0;
      s_ctrl_q    <= '0;
      in_ready_q  <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      m_data_q    <= m_data_d;
      m_ctrl_q    <= m_ctrl_d;
      s_data_q    <= s_data_d;
      s_ctrl_q    <= s_ctrl_d;
      in_ready_q  <= in_ready_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Bubbles must never present live control bits downstream
  assign out_valid = m_valid;
  assign out_data  = m_data_q;
  assign out_ctrl  = m_valid ? m_ctrl_q : '0;
  assign in_ready  = in_ready_q;
  assign stall_cnt = stall_cnt_q;

endmodule
